alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin grant,
// fixed settle time, then a response that is held until the owner takes it.
module alu_arbiter #(
  parameter int EXEC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_op,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_op,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [5:0]  alu_op,
  input  logic [15:0] alu_result,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid and ready
  // are both high; valid never waits on ready, ready may depend on valid.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t      state_q;
  logic        id_q;
  logic        last_grant_q;
  logic [5:0]  op_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [3:0]  cnt_q;
  logic [15:0] rsp_result_q;
  logic        rsp_err_q;

  logic        grant_d;
  logic        accept_d;
  logic        op_legal_d;
  logic        hs_d;
  logic [15:0] result_d;
  logic        err_d;

  // Contested requests go to whoever did not finish last.
  always_comb begin
    grant_d = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_d = ~last_grant_q;
    end else if (req1_valid) begin
      grant_d = 1'b1;
    end
  end

  assign accept_d   = (state_q == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state_q == S_IDLE) && req0_valid && !grant_d;
  assign req1_ready = (state_q == S_IDLE) && req1_valid && grant_d;

  assign op_legal_d = (op_q <= 6'd4) ||
                      ((op_q >= 6'd8) && (op_q <= 6'd11)) ||
                      (op_q == 6'd16);

  always_comb begin
    result_d = alu_result;
    err_d    = 1'b0;
    if (!op_legal_d) begin
      result_d = 16'h0000;
      err_d    = 1'b1;
    end else if ((op_q == 6'd3) && (b_q == 8'd0)) begin
      result_d = 16'hFFFF;
      err_d    = 1'b1;
    end
  end

  assign hs_d = (state_q == S_RESP) && (id_q ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= 6'd0;
      a_q          <= 8'd0;
      b_q          <= 8'd0;
      cnt_q        <= 4'd0;
      rsp_result_q <= 16'd0;
      rsp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            id_q    <= grant_d;
            op_q    <= grant_d ? req1_op : req0_op;
            a_q     <= grant_d ? req1_a : req0_a;
            b_q     <= grant_d ? req1_b : req0_b;
            cnt_q   <= 4'd0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q == LAST_CNT) begin
            rsp_result_q <= result_d;
            rsp_err_q    <= err_d;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_RESP: begin
          if (hs_d) begin
            last_grant_q <= id_q;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The ALU sees zeros while idle so it never toggles on stale operands.
  assign alu_op     = (state_q != S_IDLE) ? op_q : 6'd0;
  assign alu_a      = (state_q != S_IDLE) ? a_q : 8'd0;
  assign alu_b      = (state_q != S_IDLE) ? b_q : 8'd0;
  assign rsp0_valid = (state_q == S_RESP) && !id_q;
  assign rsp1_valid = (state_q == S_RESP) && id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule
